// File: rtl/scan_sequencer_3b.sv
// Round-robin slot scanner feeding a 3-to-8 decoder: steps through enabled mask
// slots in ascending order, holding each for a dwell time followed by a blanking gap.
module scan_sequencer_3b #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel_out,
  output logic               en_out,
  output logic               frame_done,
  output logic               busy
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t             r_state;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [BW-1:0]      r_blank_cnt;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic [2:0]         w_first;
  logic [2:0]         w_next;
  logic               w_wrap;
  logic               w_go;
  logic               w_slot_end;

  assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_go        = run && (mask != 8'h00);

  // A slot ends after its last ACTIVE cycle when there is no blanking,
  // otherwise after its last BLANK cycle.
  assign w_slot_end = ((r_state == ACTIVE) && (r_dwell_cnt <= DWELL_W'(1)) && (BLANK_CYC == 0))
                   || ((r_state == BLANK) && (r_blank_cnt <= BW'(1)));

  always_comb begin
    logic [2:0] cand;
    w_first = 3'd0;
    w_next  = sel_out;
    cand    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) w_first = 3'(i);
    end
    // Walk offsets from far to near so the nearest set bit above the current
    // slot wins; offset 8 aliases to the current slot and is found last.
    for (int k = 8; k >= 1; k--) begin
      cand = sel_out + 3'(k);
      if (mask[cand]) w_next = cand;
    end
    w_wrap = (w_next <= sel_out);
  end

  // NOTE: every state register is assigned with <= so all of them update
  // together on the edge; mixing in = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dwell_cnt <= '0;
      r_blank_cnt <= '0;
      sel_out     <= 3'd0;
      en_out      <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_slot_end) begin
        if (w_go) begin
          r_state     <= ACTIVE;
          sel_out     <= w_next;
          r_dwell_cnt <= w_dwell_eff;
          en_out      <= 1'b1;
          frame_done  <= w_wrap;
        end else begin
          r_state <= IDLE;
          en_out  <= 1'b0;
          busy    <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            en_out <= 1'b0;
            busy   <= 1'b0;
            if (w_go) begin
              r_state     <= ACTIVE;
              sel_out     <= w_first;
              r_dwell_cnt <= w_dwell_eff;
              en_out      <= 1'b1;
              frame_done  <= 1'b1;
              busy        <= 1'b1;
            end
          end
          ACTIVE: begin
            if (r_dwell_cnt > DWELL_W'(1)) begin
              r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
            end else begin
              r_state     <= BLANK;
              en_out      <= 1'b0;
              r_blank_cnt <= BW'(BLANK_CYC);
            end
          end
          BLANK: begin
            r_blank_cnt <= r_blank_cnt - BW'(1);
          end
          default: begin
            r_state <= IDLE;
            en_out  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer_3b.sv
// Self-checking bench for scan_sequencer_3b: vector table, directed scan
// sequences, and randomized traffic against a slot-timing reference model.
module tb_scan_sequencer_3b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [7:0] mask = 8'd0;
  logic [2:0] sel, sel0;
  logic       en, fd, busy, en0, fd0, busy0;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  scan_sequencer_3b #(.DWELL_W(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .run(run), .dwell(dwell), .mask(mask),
    .sel_out(sel), .en_out(en), .frame_done(fd), .busy(busy));

  scan_sequencer_3b #(.DWELL_W(8), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .dwell(dwell), .mask(mask),
    .sel_out(sel0), .en_out(en0), .frame_done(fd0), .busy(busy0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reference model: slot position is elapsed edges since slot entry.
  typedef struct {
    bit busy;
    int sel;
    int start;
    int act;
    bit en;
    bit fd;
  } mdl_t;

  mdl_t m2, m0;

  function automatic mdl_t mstep(mdl_t s, int b, bit r, bit rn, logic [7:0] mk,
                                 logic [7:0] dw, int now);
    mdl_t n = s;
    int nx;
    bit found;
    n.fd = 1'b0;
    if (r) begin
      n.busy = 0; n.sel = 0; n.en = 0;
    end else if (!s.busy) begin
      n.en = 0;
      if (rn && mk != 0) begin
        found = 0; nx = 0;
        for (int i = 0; i < 8; i++) if (!found && mk[i]) begin nx = i; found = 1; end
        n.sel = nx; n.start = now; n.act = (dw == 0) ? 1 : int'(dw);
        n.busy = 1; n.en = 1; n.fd = 1;
      end
    end else if (now - s.start == s.act + b) begin
      if (!rn || mk == 0) begin
        n.busy = 0; n.en = 0;
      end else begin
        found = 0; nx = s.sel;
        for (int k = 1; k <= 8; k++)
          if (!found && mk[(s.sel + k) % 8]) begin nx = (s.sel + k) % 8; found = 1; end
        n.fd = (nx <= s.sel);
        n.sel = nx; n.start = now; n.act = (dw == 0) ? 1 : int'(dw); n.en = 1;
      end
    end else begin
      n.en = (now - s.start) < s.act;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    t++;
    m2 = mstep(m2, 2, rst, run, mask, dwell, t);
    m0 = mstep(m0, 0, rst, run, mask, dwell, t);
    #1;
    if (cmp_en) begin
      check("model_b2", {29'(sel), en, fd, busy}, {29'(m2.sel), m2.en, m2.fd, m2.busy});
      check("model_b0", {29'(sel0), en0, fd0, busy0}, {29'(m0.sel), m0.en, m0.fd, m0.busy});
    end
  endtask

  int q_sel[$];
  int q_t[$];
  int q_fd[$];
  int en_cnt, fd_cnt;

  task automatic record(input int n);
    bit prev_en = 0;
    q_sel.delete(); q_t.delete(); q_fd.delete();
    en_cnt = 0; fd_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (en) en_cnt++;
      if (fd) fd_cnt++;
      if (en && !prev_en) begin q_sel.push_back(int'(sel)); q_t.push_back(k); q_fd.push_back(int'(fd)); end
      prev_en = en;
    end
  endtask

  task automatic wait_entry(input int s, input string name);
    bit found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (en && sel == 3'(s)) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  typedef struct {
    bit         rst;
    bit         run;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    bit         en;
    bit         fd;
    bit         busy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit r, bit rn, logic [7:0] m, logic [7:0] d,
                              logic [2:0] s, bit e, bit f, bit b);
    vec_t v;
    v.rst = r; v.run = rn; v.mask = m; v.dwell = d;
    v.sel = s; v.en = e; v.fd = f; v.busy = b;
    return v;
  endfunction

  initial begin
    m2 = '{default: 0};
    m0 = '{default: 0};

    // Reset, empty mask, late start, graceful stop, restart, reset mid-ACTIVE.
    vecs[0]  = mk(1, 0, 8'h00, 8'd0, 3'd0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h00, 8'd0, 3'd0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 8'h00, 8'd0, 3'd0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 8'h80, 8'd1, 3'd7, 1, 1, 1);
    vecs[4]  = mk(0, 1, 8'h80, 8'd1, 3'd7, 0, 0, 1);
    vecs[5]  = mk(0, 1, 8'h80, 8'd1, 3'd7, 0, 0, 1);
    vecs[6]  = mk(0, 1, 8'h80, 8'd1, 3'd7, 1, 1, 1);
    vecs[7]  = mk(0, 0, 8'h80, 8'd1, 3'd7, 0, 0, 1);
    vecs[8]  = mk(0, 0, 8'h80, 8'd1, 3'd7, 0, 0, 1);
    vecs[9]  = mk(0, 0, 8'h80, 8'd1, 3'd7, 0, 0, 0);
    vecs[10] = mk(0, 0, 8'h80, 8'd1, 3'd7, 0, 0, 0);
    vecs[11] = mk(0, 1, 8'h24, 8'd2, 3'd2, 1, 1, 1);
    vecs[12] = mk(0, 1, 8'h24, 8'd2, 3'd2, 1, 0, 1);
    vecs[13] = mk(0, 1, 8'h24, 8'd2, 3'd2, 0, 0, 1);
    vecs[14] = mk(1, 1, 8'h24, 8'd2, 3'd0, 0, 0, 0);
    vecs[15] = mk(0, 1, 8'h24, 8'd2, 3'd2, 1, 1, 1);

    #2;
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; run = vecs[i].run; mask = vecs[i].mask; dwell = vecs[i].dwell;
      tick();
      check($sformatf("vec%0d", i), {29'(sel), en, fd, busy},
            {29'(vecs[i].sel), vecs[i].en, vecs[i].fd, vecs[i].busy});
    end

    // Full scan: 8 slots of 3+2 cycles, frame every 40 cycles.
    run = 0; do_reset();
    run = 1; mask = 8'hFF; dwell = 8'd3;
    record(41);
    check("full_entries", q_sel.size(), 9);
    for (int i = 0; i < 9 && i < q_sel.size(); i++) begin
      check($sformatf("full_sel%0d", i), q_sel[i], i % 8);
      check($sformatf("full_t%0d", i), q_t[i], 5 * i);
      check($sformatf("full_fd%0d", i), q_fd[i], (i == 0 || i == 8) ? 1 : 0);
    end
    check("full_en_cnt", en_cnt, 25);
    check("full_fd_cnt", fd_cnt, 2);

    // Sparse mask: 2,5,7,2 with period 9.
    run = 0; do_reset();
    run = 1; mask = 8'b1010_0100; dwell = 8'd1;
    record(10);
    check("sparse_entries", q_sel.size(), 4);
    for (int i = 0; i < 4 && i < q_sel.size(); i++) begin
      check($sformatf("sparse_sel%0d", i), q_sel[i], (i == 1) ? 5 : (i == 2) ? 7 : 2);
      check($sformatf("sparse_t%0d", i), q_t[i], 3 * i);
      check($sformatf("sparse_fd%0d", i), q_fd[i], (i == 0 || i == 3) ? 1 : 0);
    end

    // Single slot, dwell 0, no blanking: constant index, enable and frame pulse.
    run = 0; do_reset();
    run = 1; mask = 8'h10; dwell = 8'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("single_k%0d", k), {29'(sel0), en0, fd0, busy0}, {29'd4, 1'b1, 1'b1, 1'b1});
    end

    // Graceful stop during slot 3, then mask change during slot 5.
    run = 0; do_reset();
    run = 1; mask = 8'hFF; dwell = 8'd4;
    wait_entry(3, "stop_reach3");
    run = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("stop_k%0d", k), {sel, en, busy}, {3'd3, k < 4, k < 6});
    end
    run = 1;
    wait_entry(5, "resample_reach5");
    mask = 8'h01;
    repeat (6) tick();
    check("resample_next", {sel, en, fd}, {3'd0, 1'b1, 1'b1});

    // Randomized traffic against the reference model on both instances.
    run = 0; do_reset();
    cmp_en = 1;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 8'h00;
          1: mask = 8'h01 << $urandom_range(0, 7);
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 5));
      tick();
    end
    cmp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
